// File: rtl/seq_divider_4bits_if.sv
// Operand/result bundle of the sequential divider. The front end (master)
// drives start and operands; the divider (slave) returns registered results.
interface seq_divider_4bits_if #(
  parameter int WIDTH = 4
);
  // Handshake: i_start is a request that is honoured only while the divider
  // is idle; o_done is a one-cycle pulse marking fresh o_quotient/o_remainder/
  // o_div_zero, which then hold until the next o_done or reset.
  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_remainder, o_busy, o_done, o_div_zero
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_remainder, o_busy, o_done, o_div_zero
  );
endinterface

// File: rtl/seq_divider_4bits.sv
// Unsigned restoring divider: one shift-and-trial-subtract step per clock,
// results registered on DONE entry and held until the next completion.
module seq_divider_4bits #(
  parameter int WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  seq_divider_4bits_if.slave   bus,
  output logic [1:0]           o_dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;

  // Trial subtract in the same add-invert-plus-one form as the adder block;
  // a set top bit means the subtraction borrowed and S is restored.
  always_comb begin
    s   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    t   = s + ~{1'b0, d_q} + (WIDTH+1)'(1);
    r_d = t[WIDTH] ? s : t;
    q_d = {q_q[WIDTH-2:0], ~t[WIDTH]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.i_start) begin
            if (bus.i_divisor != '0) begin
              r_q     <= '0;
              q_q     <= bus.i_dividend;
              d_q     <= bus.i_divisor;
              cnt_q   <= CW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              quot_q  <= '1;
              rem_q   <= bus.i_dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_quotient  = quot_q;
  assign bus.o_remainder = rem_q;
  assign bus.o_div_zero  = dz_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_seq_divider_4bits.sv
// Directed bench for seq_divider_4bits: expected results go into a queue at
// issue time and a negedge monitor pops them whenever o_done is seen.
module tb_seq_divider_4bits;
  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  seq_divider_4bits_if #(.WIDTH(W)) dif ();

  seq_divider_4bits #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (dif.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {div_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_z;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && dif.o_done) begin
      logic [2*W:0] act;
      logic [2*W:0] exp;
      act = {dif.o_div_zero, dif.o_quotient, dif.o_remainder};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got %h with no expected result", act);
      end else begin
        exp = exp_q.pop_front();
        if (act != exp) begin
          failures++;
          $display("FAIL result: got z/q/r %h expected %h", act, exp);
        end
      end
    end
  end

  // driver: issue a division, count busy cycles, check latency and that the
  // previous results hold until the new o_done
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    int held_bad;
    exp_q.push_back({ez, eq, er});
    @(negedge clk);
    dif.i_start    = 1'b1;
    dif.i_dividend = a;
    dif.i_divisor  = b;
    @(posedge clk);
    @(negedge clk);
    dif.i_start    = 1'b0;
    dif.i_dividend = $urandom_range(15, 0);
    dif.i_divisor  = $urandom_range(15, 0);
    lat      = 1;
    busy_cnt = 0;
    held_bad = 0;
    while (!dif.o_done && lat < 20) begin
      if (dif.o_busy) busy_cnt++;
      if (dif.o_quotient != last_q || dif.o_remainder != last_r ||
          dif.o_div_zero != last_z) held_bad++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_%0d_%0d", a, b), lat, exp_lat);
    check($sformatf("busy_cycles_%0d_%0d", a, b), busy_cnt, exp_busy);
    check($sformatf("held_before_done_%0d_%0d", a, b), held_bad, 0);
    last_q = eq;
    last_r = er;
    last_z = ez;
    @(negedge clk);
    check("done_one_cycle", int'(dif.o_done), 0);
  endtask

  initial begin
    int done_cnt;
    rst            = 1'b1;
    dif.i_start    = 1'b0;
    dif.i_dividend = '0;
    dif.i_divisor  = '0;
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_quotient", int'(dif.o_quotient), 0);
    check("reset_remainder", int'(dif.o_remainder), 0);
    check("reset_flags", int'({dif.o_busy, dif.o_done, dif.o_div_zero}), 0);
    check("reset_state", int'(dbg_state), 0);
    rst = 1'b0;

    do_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5, 4);
    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4);
    do_div(4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 5, 4);
    do_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, 4);
    do_div(4'd0, 4'd3, 4'd0, 4'd0, 1'b0, 5, 4);
    do_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1, 0);

    // reset during the second RUN cycle aborts without o_done
    @(negedge clk);
    dif.i_start    = 1'b1;
    dif.i_dividend = 4'd12;
    dif.i_divisor  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    dif.i_start = 1'b0;
    check("abort_running", int'(dif.o_busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_quotient", int'(dif.o_quotient), 0);
    check("abort_remainder", int'(dif.o_remainder), 0);
    check("abort_flags", int'({dif.o_busy, dif.o_done, dif.o_div_zero}), 0);
    check("abort_state", int'(dbg_state), 0);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", int'(dif.o_done), 0);
    do_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, 4);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst            = 1'b1;
    dif.i_start    = 1'b1;
    dif.i_dividend = 4'd6;
    dif.i_divisor  = 4'd2;
    @(negedge clk);
    rst         = 1'b0;
    dif.i_start = 1'b0;
    check("reset_beats_start", int'({dbg_state, dif.o_busy, dif.o_done}), 0);
    check("reset_beats_start_q", int'(dif.o_quotient), 0);
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;

    do_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5, 4);

    // 10 / 3 with stray starts during RUN and in the DONE cycle
    exp_q.push_back({1'b0, 4'd3, 4'd1});
    @(negedge clk);
    dif.i_start    = 1'b1;
    dif.i_dividend = 4'd10;
    dif.i_divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    dif.i_start = 1'b0;
    @(negedge clk);
    dif.i_start    = 1'b1;
    dif.i_dividend = 4'd8;
    dif.i_divisor  = 4'd2;
    @(negedge clk);
    dif.i_start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10 && done_cnt == 0; i++) begin
      if (dif.o_done) begin
        done_cnt++;
        dif.i_start = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("stray_start_done_seen", done_cnt, 1);
    @(negedge clk);
    dif.i_start = 1'b0;
    check("stray_start_idle", int'({dbg_state, dif.o_busy, dif.o_done}), 0);
    last_q = 4'd3;
    last_r = 4'd1;
    last_z = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_start_no_run", int'(dif.o_busy), 0);
    do_div(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5, 4);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
